// File: rtl/arb_mux_pkg.sv
// Shared definitions for the arb_mux round-robin arbitrated multiplexer.
// Lock-state encoding is only used when ARB_MUX_LOCK_EN is defined.
package arb_mux_pkg;

    localparam int unsigned WIDTH_DEF    = 32'd32;
    localparam int unsigned CHANNELS_DEF = 32'd8;

    typedef enum logic {
        LOCK_IDLE   = 1'b0,
        LOCK_LOCKED = 1'b1
    } lock_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 32'd0;
        while ((32'd1 << r) < value) begin
            r = r + 32'd1;
        end
        return (r == 32'd0) ? 32'd1 : r;
    endfunction

endpackage

// File: rtl/arb_mux_if.sv
// Channel-side and consumer-side handshake bundle for arb_mux.
// in_last/out_last exist only when ARB_MUX_LOCK_EN is defined.
interface arb_mux_if #(
    parameter int unsigned Width    = arb_mux_pkg::WIDTH_DEF,
    parameter int unsigned Channels = arb_mux_pkg::CHANNELS_DEF
);
    import arb_mux_pkg::*;

    localparam int unsigned SelW = clog2(Channels);

    logic [Channels*Width-1:0] in_data;
    logic [Channels-1:0]       in_valid;
    logic [Channels-1:0]       in_ready;
    logic [Width-1:0]          out_data;
    logic [SelW-1:0]           out_sel;
    logic                      out_valid;
    logic                      out_ready;
`ifdef ARB_MUX_LOCK_EN
    logic [Channels-1:0]       in_last;
    logic                      out_last;
`endif

    modport master (
`ifdef ARB_MUX_LOCK_EN
        output in_last,
        input  out_last,
`endif
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );

    modport slave (
`ifdef ARB_MUX_LOCK_EN
        input  in_last,
        output out_last,
`endif
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker: first request at index >= ptr,
// wrapping to the lowest request below ptr. Works for any request count.
module rr_pick #(
    parameter int unsigned N    = 32'd8,
    parameter int unsigned SelW = 32'd3
) (
    input  logic [N-1:0]    req,
    input  logic [SelW-1:0] ptr,
    output logic [SelW-1:0] g,
    output logic            any
);

    logic [SelW-1:0] g_hi_s;
    logic [SelW-1:0] g_lo_s;
    logic            any_hi_s;
    logic            any_lo_s;

    // Downward scan so the lowest qualifying index in each half wins
    always_comb begin
        g_hi_s   = {SelW{1'b0}};
        g_lo_s   = {SelW{1'b0}};
        any_hi_s = 1'b0;
        any_lo_s = 1'b0;
        for (int j = int'(N) - 1; j >= 0; j--) begin
            if (req[j] && (SelW'(j) >= ptr)) begin
                any_hi_s = 1'b1;
                g_hi_s   = SelW'(j);
            end else if (req[j]) begin
                any_lo_s = 1'b1;
                g_lo_s   = SelW'(j);
            end else begin
                any_lo_s = any_lo_s;
            end
        end
    end

    assign any = any_hi_s || any_lo_s;
    assign g   = any_hi_s ? g_hi_s : g_lo_s;

endmodule

// File: rtl/arb_mux.sv
// N-channel round-robin arbitrated mux with a registered output stage.
// Defining ARB_MUX_LOCK_EN keeps a granted channel until its in_last beat.
module arb_mux #(
    parameter int unsigned Width    = arb_mux_pkg::WIDTH_DEF,
    parameter int unsigned Channels = arb_mux_pkg::CHANNELS_DEF
) (
    input logic       clk,
    input logic       reset,
    arb_mux_if.slave  bus
);
    import arb_mux_pkg::*;

    localparam int unsigned SelW = clog2(Channels);

    logic [SelW-1:0]     ptr_r;
    logic [Width-1:0]    out_data_r;
    logic [SelW-1:0]     out_sel_r;
    logic                out_valid_r;
    logic [Channels-1:0] eligible_s;
    logic [Channels-1:0] in_ready_s;
    logic [SelW-1:0]     g_s;
    logic                any_s;
    logic                load_s;
    logic [Width-1:0]    sel_data_s;
`ifdef ARB_MUX_LOCK_EN
    lock_state_e         lock_r;
    logic [SelW-1:0]     lock_ch_r;
    logic                out_last_r;
    logic                sel_last_s;
`endif

    function automatic logic [SelW-1:0] next_ptr(input logic [SelW-1:0] idx);
        return (idx == SelW'(Channels - 32'd1)) ? {SelW{1'b0}} : idx + SelW'(1'b1);
    endfunction

    // While locked, only the owning channel may compete
    always_comb begin
        eligible_s = bus.in_valid;
`ifdef ARB_MUX_LOCK_EN
        if (lock_r == LOCK_LOCKED) begin
            for (int j = 0; j < int'(Channels); j++) begin
                eligible_s[j] = bus.in_valid[j] && (lock_ch_r == SelW'(j));
            end
        end else begin
            eligible_s = bus.in_valid;
        end
`endif
    end

    rr_pick #(.N(Channels), .SelW(SelW)) u_pick (
        .req (eligible_s),
        .ptr (ptr_r),
        .g   (g_s),
        .any (any_s)
    );

    assign load_s = !reset && (!out_valid_r || bus.out_ready) && any_s;

    // Grant decode and data/last selection for the winning channel
    always_comb begin
        in_ready_s = {Channels{1'b0}};
        sel_data_s = {Width{1'b0}};
`ifdef ARB_MUX_LOCK_EN
        sel_last_s = 1'b0;
`endif
        for (int j = 0; j < int'(Channels); j++) begin
            if (g_s == SelW'(j)) begin
                in_ready_s[j] = load_s;
                sel_data_s    = bus.in_data[j*Width +: Width];
`ifdef ARB_MUX_LOCK_EN
                sel_last_s    = bus.in_last[j];
`endif
            end else begin
                in_ready_s[j] = 1'b0;
            end
        end
    end

    // Output register, round-robin pointer and packet lock state
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {Width{1'b0}};
            out_sel_r   <= {SelW{1'b0}};
            ptr_r       <= {SelW{1'b0}};
`ifdef ARB_MUX_LOCK_EN
            out_last_r  <= 1'b0;
            lock_r      <= LOCK_IDLE;
            lock_ch_r   <= {SelW{1'b0}};
`endif
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= sel_data_s;
            out_sel_r   <= g_s;
`ifdef ARB_MUX_LOCK_EN
            out_last_r  <= sel_last_s;
            case (lock_r)
                LOCK_IDLE: begin
                    ptr_r <= next_ptr(g_s);
                    if (!sel_last_s) begin
                        lock_r    <= LOCK_LOCKED;
                        lock_ch_r <= g_s;
                    end
                end
                LOCK_LOCKED: begin
                    if (sel_last_s) begin
                        lock_r <= LOCK_IDLE;
                        ptr_r  <= next_ptr(lock_ch_r);
                    end
                end
                default: begin
                    lock_r <= LOCK_IDLE;
                end
            endcase
`else
            ptr_r       <= next_ptr(g_s);
`endif
        end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_data  = out_data_r;
    assign bus.out_sel   = out_sel_r;
    assign bus.out_valid = out_valid_r;
`ifdef ARB_MUX_LOCK_EN
    assign bus.out_last  = out_last_r;
`endif

endmodule

// File: tb/tb_arb_mux.sv
// Scoreboard bench for arb_mux: an 8-channel and a 5-channel instance,
// directed stimulus pushes expected beats, negedge monitors pop and compare.
module tb_arb_mux;

    typedef struct packed {
        logic        last;
        logic [2:0]  sel;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clk = ~clk;

    arb_mux_if #(.Width(32), .Channels(8)) bus_a ();
    arb_mux_if #(.Width(32), .Channels(5)) bus_b ();

    arb_mux #(.Width(32), .Channels(8)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    arb_mux #(.Width(32), .Channels(5)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    function automatic logic [31:0] mk(input int ch, input int tag);
        return {8'hC0 + 8'(tag), 8'(ch), 16'h5A00 + 16'(ch)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_a(input int tag);
        for (int j = 0; j < 8; j++) bus_a.in_data[j*32 +: 32] = mk(j, tag);
    endtask

    task automatic fill_b(input int tag);
        for (int j = 0; j < 5; j++) bus_b.in_data[j*32 +: 32] = mk(j, tag);
    endtask

    task automatic push_a(input int ch, input int tag, input logic last);
        exp_t e;
        e.last = last;
        e.sel  = 3'(ch);
        e.data = mk(ch, tag);
        q_a.push_back(e);
    endtask

    task automatic push_b(input int ch, input int tag);
        exp_t e;
        e.last = 1'b0;
        e.sel  = 3'(ch);
        e.data = mk(ch, tag);
        q_b.push_back(e);
    endtask

    // Monitor for the 8-channel instance: every accepted beat must match the queue head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && bus_a.out_valid && bus_a.out_ready) begin
                if (q_a.size() == 0) begin
                    chk("a_unexpected_beat", 64'(bus_a.out_sel), 64'hFFFF);
                end else begin
                    e = q_a.pop_front();
                    chk("a_sel", 64'(bus_a.out_sel), 64'(e.sel));
                    chk("a_data", 64'(bus_a.out_data), 64'(e.data));
`ifdef ARB_MUX_LOCK_EN
                    chk("a_last", 64'(bus_a.out_last), 64'(e.last));
`endif
                end
            end
        end
    end

    // Monitor for the 5-channel instance
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && bus_b.out_valid && bus_b.out_ready) begin
                if (q_b.size() == 0) begin
                    chk("b_unexpected_beat", 64'(bus_b.out_sel), 64'hFFFF);
                end else begin
                    e = q_b.pop_front();
                    chk("b_sel", 64'(bus_b.out_sel), 64'(e.sel));
                    chk("b_data", 64'(bus_b.out_data), 64'(e.data));
                end
            end
        end
    end

    initial begin
        logic [7:0] oh8;
        logic [4:0] oh5;
        int         guard;

        reset           = 1'b1;
        bus_a.in_valid  = 8'hFF;
        bus_a.out_ready = 1'b1;
        bus_b.in_valid  = 5'h1F;
        bus_b.out_ready = 1'b1;
        bus_a.in_data   = '0;
        bus_b.in_data   = '0;
`ifdef ARB_MUX_LOCK_EN
        bus_a.in_last   = 8'h00;
        bus_b.in_last   = 5'h00;
`endif
        fill_a(0);
        fill_b(0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_ready", 64'(bus_a.in_ready), 64'd0);
        chk("rst_a_valid", 64'(bus_a.out_valid), 64'd0);
        chk("rst_a_data", 64'(bus_a.out_data), 64'd0);
        chk("rst_a_sel", 64'(bus_a.out_sel), 64'd0);
        chk("rst_b_ready", 64'(bus_b.in_ready), 64'd0);
        chk("rst_b_valid", 64'(bus_b.out_valid), 64'd0);

        reset          = 1'b0;
        bus_a.in_valid = 8'h00;
        bus_b.in_valid = 5'h00;
        step();
        chk("idle_a_ready", 64'(bus_a.in_ready), 64'd0);
        chk("idle_a_valid", 64'(bus_a.out_valid), 64'd0);
        chk("idle_b_valid", 64'(bus_b.out_valid), 64'd0);

        // all eight channels requesting: one grant per channel, then wrap to 0
        fill_a(1);
        bus_a.in_valid = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            push_a(i % 8, 1, 1'b0);
            oh8 = 8'd1 << (i % 8);
            #1;
            chk("rr_a_ready", 64'(bus_a.in_ready), 64'(oh8));
            step();
        end
        bus_a.in_valid = 8'h00;
        step();
        chk("drain_a_valid", 64'(bus_a.out_valid), 64'd0);

        // stall with a held beat, then release: next beat loads in the same cycle
        bus_a.in_valid = 8'b0000_1010;
        push_a(1, 1, 1'b0);
        step();
        bus_a.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_sel", 64'(bus_a.out_sel), 64'd1);
            chk("stall_data", 64'(bus_a.out_data), 64'(mk(1, 1)));
            chk("stall_valid", 64'(bus_a.out_valid), 64'd1);
            chk("stall_ready", 64'(bus_a.in_ready), 64'd0);
            step();
        end
        bus_a.out_ready = 1'b1;
        push_a(3, 1, 1'b0);
        #1;
        chk("release_ready", 64'(bus_a.in_ready), 64'(8'b0000_1000));
        step();
        bus_a.in_valid = 8'h00;
        step();

        // five channels: walk ptr to 4, then ch4 and ch0 only -> 4 then wrap to 0
        fill_b(2);
        bus_b.in_valid = 5'b01111;
        for (int i = 0; i < 4; i++) begin
            push_b(i, 2);
            oh5 = 5'd1 << i;
            #1;
            chk("b_walk_ready", 64'(bus_b.in_ready), 64'(oh5));
            step();
        end
        bus_b.in_valid = 5'b10001;
        push_b(4, 2);
        #1;
        chk("b_wrap_ready4", 64'(bus_b.in_ready), 64'(5'b10000));
        step();
        push_b(0, 2);
        #1;
        chk("b_wrap_ready0", 64'(bus_b.in_ready), 64'(5'b00001));
        step();
        bus_b.in_valid = 5'b00000;
        step();
        step();

        // reset while a beat is held: beat discarded, ptr back to 0
        fill_a(3);
        bus_a.in_valid  = 8'hFF;
        bus_a.out_ready = 1'b0;
        step();
        chk("mid_valid", 64'(bus_a.out_valid), 64'd1);
        chk("mid_sel", 64'(bus_a.out_sel), 64'd4);
        reset = 1'b1;
        step();
        chk("mrst_valid", 64'(bus_a.out_valid), 64'd0);
        chk("mrst_sel", 64'(bus_a.out_sel), 64'd0);
        chk("mrst_data", 64'(bus_a.out_data), 64'd0);
        chk("mrst_gate", 64'(bus_a.in_ready), 64'd0);
        reset           = 1'b0;
        bus_a.in_valid  = 8'b1000_0100;
        bus_a.out_ready = 1'b1;
        push_a(2, 3, 1'b0);
        #1;
        chk("ptr0_ready", 64'(bus_a.in_ready), 64'(8'b0000_0100));
        step();
        push_a(7, 3, 1'b0);
        #1;
        chk("ptr3_ready", 64'(bus_a.in_ready), 64'(8'b1000_0000));
        step();
        bus_a.in_valid = 8'h00;
        step();

`ifdef ARB_MUX_LOCK_EN
        // ch2 three-beat packet with a bubble; ch3 waits until ch2's last beat
        fill_a(4);
        bus_a.in_last  = 8'h00;
        bus_a.in_valid = 8'b0000_1100;
        push_a(2, 4, 1'b0);
        #1;
        chk("lk_first", 64'(bus_a.in_ready), 64'(8'b0000_0100));
        step();
        bus_a.in_valid = 8'b0000_1000;
        #1;
        chk("lk_bubble", 64'(bus_a.in_ready), 64'd0);
        step();
        fill_a(5);
        bus_a.in_valid = 8'b0000_1100;
        push_a(2, 5, 1'b0);
        #1;
        chk("lk_second", 64'(bus_a.in_ready), 64'(8'b0000_0100));
        step();
        fill_a(6);
        bus_a.in_last = 8'b0000_0100;
        push_a(2, 6, 1'b1);
        #1;
        chk("lk_third", 64'(bus_a.in_ready), 64'(8'b0000_0100));
        step();
        bus_a.in_valid = 8'b0000_1000;
        bus_a.in_last  = 8'b0000_1000;
        push_a(3, 6, 1'b1);
        #1;
        chk("lk_after", 64'(bus_a.in_ready), 64'(8'b0000_1000));
        step();
        bus_a.in_valid = 8'h00;
        bus_a.in_last  = 8'h00;
        step();
`endif

        guard = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && guard < 20) begin
            step();
            guard++;
        end
        chk("sb_empty", 64'(q_a.size() + q_b.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
